uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- Parametrised, oversampling UART receiver; successor to the fixed 8-bit single-stop receiver in the peripheral subsystem.
- Supports configurable data width, parity mode and stop-bit count, with 3-sample majority voting per bit.
- Reports parity, framing and break errors, and buffers each received word in a one-entry valid/ready holding register with overrun detection.
- Sits between the board RX pin and the debug/loader unit.

Parameters:
- NB_DATA, 8, data bits per frame, legal range 5..9, sent LSB first.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- NB_STOP, 1, stop bits checked, 1 or 2.
- CLK_FREQ, 100000000, system clock in Hz.
- BAUD_RATE, 115200, line rate in baud.
- OVERSAMPLE, 16, sample ticks per bit; even, at least 8.

Ports:
- clk, in, 1, system clock; all logic on its rising edge.
- i_rst, in, 1, reset, synchronous active-high.
- i_rx, in, 1, asynchronous serial line; idles high.
- i_rx_ready, in, 1, consumer accepts the held word when high while o_rx_valid is high.
- o_rx_data, out, NB_DATA, received word.
- o_rx_valid, out, 1, held word available; level signal.
- o_parity_err, out, 1, held word failed parity check; qualified by o_rx_valid.
- o_frame_err, out, 1, a stop bit sampled low; qualified by o_rx_valid.
- o_break, out, 1, break frame (line low through all bits); qualified by o_rx_valid.
- o_overrun, out, 1, one-cycle pulse when a completed frame is dropped.
- o_busy, out, 1, high from start-bit detection until return to IDLE.

Behaviour:
- Reset, applied synchronously on the clk edge while i_rst=1:
  - All outputs go to 0.
  - Synchroniser flops go to 1.
  - FSM goes to IDLE.
  - Tick and sample counters go to 0.
  - Any partial frame or held word is discarded.
- Synchroniser: i_rx passes through 2 flops (rx_s). All logic uses rx_s only.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer truncation; 54 at defaults.
  - Free-running counter 0..DIV-1; one-cycle tick when the count equals DIV-1.
- Sample counter s runs 0..OVERSAMPLE-1, advances on each tick and wraps to 0. Let H = OVERSAMPLE/2.
- Per-bit sampling: rx_s is sampled at s = H-1, H and H+1. The bit value is the majority of the 3 samples, decided on the tick where s = H+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a tick with rx_s=0, go to START with s=0 and o_busy=1.
  - START, at the decision tick:
    - Majority 1 means a false start: go to IDLE, o_busy=0.
    - Majority 0: continue; at s=OVERSAMPLE-1 go to DATA with bit count 0.
  - DATA: each decided bit shifts in LSB first. After NB_DATA bits (at s=OVERSAMPLE-1), go to PARITY if PARITY!=0, else STOP.
  - PARITY, evaluated at the decision tick:
    - Even mode: error if XOR(data, parity bit) = 1.
    - Odd mode: error if XOR(data, parity bit) = 0.
    - At s=OVERSAMPLE-1, go to STOP.
  - STOP:
    - Each stop bit whose majority is 0 sets frame error.
    - A frame completes at the decision tick of the last stop bit (mid-bit, allowing re-sync). The FSM goes straight to IDLE and o_busy drops on the same edge.
- Break: frame error set, data all 0, and parity bit 0 (when present).
- Completion, with latency of 1 clk after the completion tick:
  - Holding register empty (o_rx_valid=0), or i_rx_ready=1 in that same cycle: load data and error flags, o_rx_valid=1, no overrun.
  - Otherwise: new frame dropped, held word and its flags unchanged, o_overrun=1 for one cycle.
- Handshake: o_rx_valid falls on the edge after a cycle with o_rx_valid=1 and i_rx_ready=1, unless the same cycle loads a new word. Error flags and data stay stable while o_rx_valid=1.
- Reset mid-frame: frame is abandoned. The next falling edge after reset release starts a fresh frame.

Test Plan:
- Defaults (bit = 864 clk), i_rx_ready=0, send 8N1 0xA5 → o_rx_valid=1, o_rx_data=0xA5, all error flags 0. Valid stays held until i_rx_ready pulses, then drops the next cycle.
- PARITY=1, send 0x37 with parity bit 0 (correct is 1) → o_rx_data=0x37, o_parity_err=1. Resend with parity bit 1 → o_parity_err=0.
- Send 0x55 with stop bit 0 → o_frame_err=1, o_break=0. Send all-zero frame with stop low → o_frame_err=1, o_break=1, data 0x00.
- Glitches on idle line:
  - rx low for 200 clk (< half bit) → no o_rx_valid, o_busy returns to 0.
  - One-tick spike inside a data bit → majority rejects it; byte correct.
- Two back-to-back frames 0x11 then 0x22 with i_rx_ready=0 → data stays 0x11, o_overrun pulses once. Repeat with i_rx_ready=1 in the completion cycle → 0x22 loaded, no overrun.
- Assert i_rst during DATA bit 3 → all outputs 0 next edge. NB_DATA=9, NB_STOP=2, PARITY=2 frame 0x1A3 afterwards → received correctly, no errors.

Source files
------------

// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os -- parametrised oversampling UART receiver
//
// Receives asynchronous serial frames (start, NB_DATA data bits LSB first,
// optional parity, NB_STOP stop bits). Each bit is decided by a 3-sample
// majority vote around mid-bit. The received word and its error flags are
// held in a one-entry valid/ready register. A frame that completes while
// that register is still occupied is dropped and flagged as an overrun.
//
// Ports:
//   clk           system clock; all logic on its rising edge
//   i_rst         synchronous active-high reset
//   i_rx          asynchronous serial line, idles high
//   i_rx_ready    consumer accepts the held word while o_rx_valid is high
//   o_rx_data     received word
//   o_rx_valid    held word available (level)
//   o_parity_err  held word failed its parity check (qualified by o_rx_valid)
//   o_frame_err   a stop bit was sampled low (qualified by o_rx_valid)
//   o_break       break frame: line low through all bits (qualified by o_rx_valid)
//   o_overrun     one-cycle pulse when a completed frame is dropped
//   o_busy        high from start-bit detection until return to idle
// -----------------------------------------------------------------------------
module uart_rx_os #(
    parameter int NB_DATA    = 8,
    parameter int PARITY     = 0,
    parameter int NB_STOP    = 1,
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_rx,
    input  logic               i_rx_ready,
    output logic [NB_DATA-1:0] o_rx_data,
    output logic               o_rx_valid,
    output logic               o_parity_err,
    output logic               o_frame_err,
    output logic               o_break,
    output logic               o_overrun,
    output logic               o_busy
);

    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(NB_DATA + 1);
    localparam int H   = OVERSAMPLE / 2;

    localparam logic [CW-1:0]  TICK_LAST = CW'(DIV - 1);
    localparam logic [SW-1:0]  S_FIRST   = SW'(H - 1);
    localparam logic [SW-1:0]  S_MID     = SW'(H);
    localparam logic [SW-1:0]  S_DECIDE  = SW'(H + 1);
    localparam logic [SW-1:0]  S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(NB_DATA - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(NB_STOP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Line synchroniser and timing
    logic               rx_meta_q, rx_meta_d;
    logic               rx_s_q, rx_s_d;
    logic [CW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]      s_q, s_d;
    logic [1:0]         samp_q, samp_d;

    // Frame in flight
    state_t             state_q, state_d;
    logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [NB_DATA-1:0] shift_q, shift_d;
    logic               cur_par_bit_q, cur_par_bit_d;
    logic               cur_par_err_q, cur_par_err_d;
    logic               cur_frm_err_q, cur_frm_err_d;

    // Holding register
    logic [NB_DATA-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               parity_err_q, parity_err_d;
    logic               frame_err_q, frame_err_d;
    logic               break_q, break_d;
    logic               overrun_q, overrun_d;

    logic tick, decide, bit_end, maj, complete;
    logic fin_frm_err, fin_break;

    assign tick    = (tick_cnt_q == TICK_LAST);
    assign decide  = tick && (s_q == S_DECIDE);
    assign bit_end = tick && (s_q == S_LAST);
    // Third sample is the live line value on the decision tick.
    assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

    // Flags as they stand on the completion tick, including the last stop bit.
    assign fin_frm_err = cur_frm_err_q | ~maj;
    assign fin_break   = fin_frm_err & (shift_q == '0) & ~cur_par_bit_q;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        rx_meta_d     = i_rx;
        rx_s_d        = rx_meta_q;
        tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;
        s_d           = s_q;
        samp_d        = samp_q;
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        cur_par_bit_d = cur_par_bit_q;
        cur_par_err_d = cur_par_err_q;
        cur_frm_err_d = cur_frm_err_q;
        complete      = 1'b0;

        if (tick) begin
            if (s_q == S_FIRST) samp_d[0] = rx_s_q;
            if (s_q == S_MID)   samp_d[1] = rx_s_q;
            s_d = (s_q == S_LAST) ? '0 : s_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                s_d = '0;
                if (tick && !rx_s_q) begin
                    state_d       = ST_START;
                    cur_par_bit_d = 1'b0;
                    cur_par_err_d = 1'b0;
                    cur_frm_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (decide && maj) begin
                    // Line was high again by mid-bit: a glitch, not a start bit.
                    state_d = ST_IDLE;
                    s_d     = '0;
                end else if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (decide) shift_d = {maj, shift_q[NB_DATA-1:1]};
                if (bit_end) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d   = (PARITY != 0) ? ST_PARITY : ST_STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (decide) begin
                    cur_par_bit_d = maj;
                    cur_par_err_d = (PARITY == 1) ? (^shift_q ^ maj) : ~(^shift_q ^ maj);
                end
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (decide) begin
                    if (!maj) cur_frm_err_d = 1'b1;
                    if (bit_cnt_q == STOP_LAST) begin
                        // Finish mid-bit so the next start edge can be caught early.
                        complete = 1'b1;
                        state_d  = ST_IDLE;
                        s_d      = '0;
                    end
                end
                if (bit_end && (bit_cnt_q != STOP_LAST)) bit_cnt_d = bit_cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Holding register: a consumer accept and a new load may share one cycle.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        break_d      = break_q;
        overrun_d    = 1'b0;

        if (rx_valid_q && i_rx_ready) rx_valid_d = 1'b0;

        if (complete) begin
            if (!rx_valid_q || i_rx_ready) begin
                rx_data_d    = shift_q;
                rx_valid_d   = 1'b1;
                parity_err_d = cur_par_err_q;
                frame_err_d  = fin_frm_err;
                break_d      = fin_break;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            // Synchroniser resets to the idle line level so reset release
            // cannot look like a start bit.
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            tick_cnt_q    <= '0;
            s_q           <= '0;
            samp_q        <= '0;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            // NOTE: data and holding registers are reset as well; they are a
            // handful of flops, and a partial frame or stale word must vanish.
            shift_q       <= '0;
            cur_par_bit_q <= 1'b0;
            cur_par_err_q <= 1'b0;
            cur_frm_err_q <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            break_q       <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            rx_meta_q     <= rx_meta_d;
            rx_s_q        <= rx_s_d;
            tick_cnt_q    <= tick_cnt_d;
            s_q           <= s_d;
            samp_q        <= samp_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            cur_par_bit_q <= cur_par_bit_d;
            cur_par_err_q <= cur_par_err_d;
            cur_frm_err_q <= cur_frm_err_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            break_q       <= break_d;
            overrun_q     <= overrun_d;
        end
    end

    assign o_rx_data    = rx_data_q;
    assign o_rx_valid   = rx_valid_q;
    assign o_parity_err = parity_err_q;
    assign o_frame_err  = frame_err_q;
    assign o_break      = break_q;
    assign o_overrun    = overrun_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os -- self-checking bench for uart_rx_os
//
// Three receivers on separate lines:
//   u0  defaults (8N1, 864 clk per bit)
//   u1  8E1, 64 clk per bit
//   u2  9 data, odd parity, 2 stop bits, 64 clk per bit
// Expected words are queued when a frame is driven and popped when the
// receiver presents o_rx_valid.
// -----------------------------------------------------------------------------
module tb_uart_rx_os;

    localparam int FAST_CLK = 7372800;   // 4 clk per tick, 64 clk per bit

    typedef struct packed {
        logic [1:0] sel;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    logic       clk;
    logic       i_rst;
    logic [2:0] rx_line;
    logic [2:0] rx_ready;

    logic [7:0] d0, d1;
    logic [8:0] d2;
    logic [2:0] valid, perr, ferr, brk, ovr, busy;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   ovr_cnt [3];

    uart_rx_os u0 (
        .clk(clk), .i_rst(i_rst), .i_rx(rx_line[0]), .i_rx_ready(rx_ready[0]),
        .o_rx_data(d0), .o_rx_valid(valid[0]), .o_parity_err(perr[0]),
        .o_frame_err(ferr[0]), .o_break(brk[0]), .o_overrun(ovr[0]), .o_busy(busy[0])
    );

    uart_rx_os #(.PARITY(1), .CLK_FREQ(FAST_CLK)) u1 (
        .clk(clk), .i_rst(i_rst), .i_rx(rx_line[1]), .i_rx_ready(rx_ready[1]),
        .o_rx_data(d1), .o_rx_valid(valid[1]), .o_parity_err(perr[1]),
        .o_frame_err(ferr[1]), .o_break(brk[1]), .o_overrun(ovr[1]), .o_busy(busy[1])
    );

    uart_rx_os #(.NB_DATA(9), .PARITY(2), .NB_STOP(2), .CLK_FREQ(FAST_CLK)) u2 (
        .clk(clk), .i_rst(i_rst), .i_rx(rx_line[2]), .i_rx_ready(rx_ready[2]),
        .o_rx_data(d2), .o_rx_valid(valid[2]), .o_parity_err(perr[2]),
        .o_frame_err(ferr[2]), .o_break(brk[2]), .o_overrun(ovr[2]), .o_busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        ovr_cnt[0] = 0; ovr_cnt[1] = 0; ovr_cnt[2] = 0;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++)
            if (ovr[k] === 1'b1) ovr_cnt[k] = ovr_cnt[k] + 1;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    // ---------------------------------------------------------------- helpers
    function automatic int bit_clk(input int sel);
        return (sel == 0) ? 864 : 64;
    endfunction

    function automatic logic [8:0] dut_data(input int sel);
        case (sel)
            0:       return {1'b0, d0};
            1:       return {1'b0, d1};
            default: return d2;
        endcase
    endfunction

    function automatic logic xor_bits(input logic [8:0] d, input int nb);
        logic x = 1'b0;
        for (int i = 0; i < nb; i++) x = x ^ d[i];
        return x;
    endfunction

    // Parity bit a correct transmitter would send.
    function automatic logic good_par(input logic [8:0] d, input int nb, input int mode);
        return (mode == 1) ? xor_bits(d, nb) : ~xor_bits(d, nb);
    endfunction

    task automatic send_bit(input int sel, input logic v, input int n);
        rx_line[sel] = v;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame; optionally queues the word the receiver must present.
    // spike_bit >= 0 inverts that data bit for one tick around its centre.
    task automatic send_frame(input int sel, input logic [8:0] data, input int nb,
                              input int mode, input logic pbit, input int nstop,
                              input logic stop_val, input int gap_bits,
                              input int spike_bit, input bit push);
        int   bc;
        int   tk;
        exp_t e;
        bc = bit_clk(sel);
        tk = bc / 16;
        if (push) begin
            e.sel  = 2'(sel);
            e.data = data;
            e.perr = (mode != 0) && (pbit !== good_par(data, nb, mode));
            e.ferr = (stop_val == 1'b0);
            e.brk  = e.ferr && (data == 9'h0) && (mode == 0 || pbit == 1'b0);
            sb.push_back(e);
        end
        send_bit(sel, 1'b0, bc);
        for (int i = 0; i < nb; i++) begin
            if (i == spike_bit) begin
                send_bit(sel, data[i], 9 * tk);
                send_bit(sel, ~data[i], tk);
                send_bit(sel, data[i], bc - 10 * tk);
            end else begin
                send_bit(sel, data[i], bc);
            end
        end
        if (mode != 0) send_bit(sel, pbit, bc);
        for (int i = 0; i < nstop; i++) send_bit(sel, stop_val, bc);
        send_bit(sel, 1'b1, gap_bits * bc);
    endtask

    // Waits (bounded) for o_rx_valid, pops the scoreboard and compares.
    task automatic check_word(input int sel, input string name);
        exp_t e;
        int   n;
        n = 0;
        while (valid[sel] !== 1'b1 && n < 40 * bit_clk(sel)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (valid[sel] !== 1'b1) begin
            failures++;
            $display("FAIL %s valid: got %b want 1 (timeout)", name, valid[sel]);
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard: got word 0x%0h with nothing expected", name, dut_data(sel));
            return;
        end
        e = sb.pop_front();
        if (int'(e.sel) != sel) begin
            failures++;
            $display("FAIL %s order: got receiver %0d want %0d", name, sel, e.sel);
        end
        checks++;
        if (dut_data(sel) !== e.data) begin
            failures++;
            $display("FAIL %s data: got 0x%0h want 0x%0h", name, dut_data(sel), e.data);
        end
        checks++;
        if (perr[sel] !== e.perr) begin
            failures++;
            $display("FAIL %s parity_err: got %b want %b", name, perr[sel], e.perr);
        end
        checks++;
        if (ferr[sel] !== e.ferr) begin
            failures++;
            $display("FAIL %s frame_err: got %b want %b", name, ferr[sel], e.ferr);
        end
        checks++;
        if (brk[sel] !== e.brk) begin
            failures++;
            $display("FAIL %s break: got %b want %b", name, brk[sel], e.brk);
        end
    endtask

    // One-cycle ready pulse; valid must be gone on the following cycle.
    task automatic accept(input int sel, input string name);
        rx_ready[sel] = 1'b1;
        @(negedge clk);
        rx_ready[sel] = 1'b0;
        checks++;
        if (valid[sel] !== 1'b0) begin
            failures++;
            $display("FAIL %s accept: valid got %b want 0", name, valid[sel]);
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        i_rst    = 1'b1;
        rx_line  = 3'b111;
        rx_ready = 3'b000;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({valid[k], perr[k], ferr[k], brk[k], ovr[k], busy[k], dut_data(k)} !== 15'h0) begin
                failures++;
                $display("FAIL reset_outputs u%0d: got v%b p%b f%b b%b o%b busy%b d0x%0h want all 0",
                         k, valid[k], perr[k], ferr[k], brk[k], ovr[k], busy[k], dut_data(k));
            end
        end
        i_rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, 2, -1, 1);
        check_word(0, "basic_a5");
        repeat (100) @(negedge clk);
        checks++;
        if (valid[0] !== 1'b1 || d0 !== 8'hA5) begin
            failures++;
            $display("FAIL basic_hold: got valid %b data 0x%0h want 1 0xa5", valid[0], d0);
        end
        accept(0, "basic_a5");
    endtask

    task automatic test_glitch();
        int n;
        rx_line[0] = 1'b0;
        repeat (100) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy_high: got %b want 1", busy[0]);
        end
        repeat (100) @(negedge clk);
        rx_line[0] = 1'b1;
        n = 0;
        while (busy[0] !== 1'b0 && n < 2 * 864) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy_low: got %b want 0", busy[0]);
        end
        repeat (864) @(negedge clk);
        checks++;
        if (valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL glitch_no_valid: got %b want 0", valid[0]);
        end
        // Spike of one tick in the middle of data bit 2 (a 1).
        send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1, 2, 2, 1);
        check_word(0, "spike_3c");
        accept(0, "spike_3c");
    endtask

    task automatic test_parity();
        send_frame(1, 9'h037, 8, 1, 1'b0, 1, 1'b1, 2, -1, 1);
        check_word(1, "parity_bad");
        accept(1, "parity_bad");
        send_frame(1, 9'h037, 8, 1, 1'b1, 1, 1'b1, 2, -1, 1);
        check_word(1, "parity_good");
        accept(1, "parity_good");
    endtask

    task automatic test_frame_err();
        send_frame(1, 9'h055, 8, 1, good_par(9'h055, 8, 1), 1, 1'b0, 3, -1, 1);
        check_word(1, "frame_55");
        accept(1, "frame_55");
        send_frame(1, 9'h000, 8, 1, 1'b0, 1, 1'b0, 3, -1, 1);
        check_word(1, "break_00");
        accept(1, "break_00");
    endtask

    task automatic test_back_to_back();
        int ovr_before;
        ovr_before = ovr_cnt[1];
        send_frame(1, 9'h011, 8, 1, good_par(9'h011, 8, 1), 1, 1'b1, 0, -1, 1);
        send_frame(1, 9'h022, 8, 1, good_par(9'h022, 8, 1), 1, 1'b1, 2, -1, 0);
        check_word(1, "b2b_held_11");
        checks++;
        if (ovr_cnt[1] - ovr_before != 1) begin
            failures++;
            $display("FAIL b2b_overrun_count: got %0d want 1", ovr_cnt[1] - ovr_before);
        end

        // 0x11 is still held; raise ready exactly in the completion cycle of 0x22.
        // Completion is the decision tick of stop bit 10: 170 ticks after detection.
        ovr_before = ovr_cnt[1];
        fork
            send_frame(1, 9'h022, 8, 1, good_par(9'h022, 8, 1), 1, 1'b1, 2, -1, 1);
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (busy[1] !== 1'b1 && n < 4 * 64);
                repeat (170 * 4 - 1) @(negedge clk);
                checks++;
                if (busy[1] !== 1'b1 || valid[1] !== 1'b1 || d1 !== 8'h11) begin
                    failures++;
                    $display("FAIL b2b_pre_completion: got busy %b valid %b data 0x%0h want 1 1 0x11",
                             busy[1], valid[1], d1);
                end
                rx_ready[1] = 1'b1;
                @(negedge clk);
                rx_ready[1] = 1'b0;
                checks++;
                if (busy[1] !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_completion_busy: got %b want 0", busy[1]);
                end
            end
        join
        checks++;
        if (ovr_cnt[1] != ovr_before) begin
            failures++;
            $display("FAIL b2b_same_cycle_overrun: got %0d want 0", ovr_cnt[1] - ovr_before);
        end
        check_word(1, "b2b_loaded_22");
        accept(1, "b2b_loaded_22");
    endtask

    task automatic test_reset_midframe();
        logic [8:0] ab;
        send_frame(2, 9'h0B5, 9, 2, good_par(9'h0B5, 9, 2), 2, 1'b1, 2, -1, 1);
        check_word(2, "pre_reset_b5");
        // Abort 0x0F8 in the middle of data bit 3 (a 1, so the line stays idle-high).
        ab = 9'h0F8;
        send_bit(2, 1'b0, 64);
        for (int i = 0; i < 3; i++) send_bit(2, ab[i], 64);
        send_bit(2, ab[3], 32);
        checks++;
        if (busy[2] !== 1'b1) begin
            failures++;
            $display("FAIL midframe_busy: got %b want 1", busy[2]);
        end
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        checks++;
        if ({valid[2], perr[2], ferr[2], brk[2], ovr[2], busy[2], d2} !== 15'h0) begin
            failures++;
            $display("FAIL midframe_reset: got v%b p%b f%b b%b o%b busy%b d0x%0h want all 0",
                     valid[2], perr[2], ferr[2], brk[2], ovr[2], busy[2], d2);
        end
        send_bit(2, 1'b1, 4 * 64);
        send_frame(2, 9'h1A3, 9, 2, good_par(9'h1A3, 9, 2), 2, 1'b1, 2, -1, 1);
        check_word(2, "post_reset_1a3");
        accept(2, "post_reset_1a3");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_frame_err();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
